// File: rtl/bitreversal_obi_arbiter.sv
// ============================================================================
// Module   : bitreversal_obi_arbiter (+ bitreversal_obi_pkg)
// Brief    : Round-robin OBI arbiter with in-order response-ID routing.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bitreversal_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module bitreversal_obi_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  bitreversal_obi_pkg::obi_req_t   master_req_i  [NUM_MASTERS],
  output bitreversal_obi_pkg::obi_resp_t  master_resp_o [NUM_MASTERS],
  output bitreversal_obi_pkg::obi_req_t   slave_req_o,
  input  bitreversal_obi_pkg::obi_resp_t  slave_resp_i
);

  localparam int c_id_w  = $clog2(NUM_MASTERS);
  localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_w-1:0] c_max_cnt  = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(MAX_OUTSTANDING - 1);
  localparam logic [c_id_w-1:0]  c_last_id  = c_id_w'(NUM_MASTERS - 1);

  logic [c_id_w-1:0]  r_rr_ptr;
  logic               r_lock;
  logic [c_id_w-1:0]  r_lock_id;
  logic [c_id_w-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;

  logic [c_id_w-1:0]  w_rr_sel;
  logic               w_any;
  int                 w_idx;
  logic [c_id_w-1:0]  w_sel;
  logic               w_valid;
  logic               w_can_issue;
  logic               w_accept;
  logic               w_stall;
  logic               w_pop;
  logic [c_id_w-1:0]  w_head;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_rr_sel = r_rr_ptr;
    w_any    = 1'b0;
    w_idx    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % NUM_MASTERS;
      if (!w_any && master_req_i[w_idx].req) begin
        w_any    = 1'b1;
        w_rr_sel = c_id_w'(w_idx);
      end
    end
  end

  assign w_sel       = r_lock ? r_lock_id : w_rr_sel;
  assign w_valid     = r_lock ? master_req_i[r_lock_id].req : w_any;
  assign w_can_issue = (r_count < c_max_cnt) | (slave_resp_i.rvalid & (r_count != '0));

  always_comb begin
    slave_req_o = '0;
    if (w_valid) begin
      slave_req_o     = master_req_i[w_sel];
      slave_req_o.req = w_can_issue;
    end
  end

  assign w_accept = slave_req_o.req & slave_resp_i.gnt;
  assign w_stall  = slave_req_o.req & ~slave_resp_i.gnt;
  assign w_pop    = slave_resp_i.rvalid & (r_count != '0);
  assign w_head   = r_fifo[r_rptr];

  // Grants are masked while reset is held so no master believes it was accepted.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      master_resp_o[m]     = '0;
      master_resp_o[m].gnt = ~rst_i & w_accept & (w_sel == c_id_w'(m));
      if (!rst_i && w_pop && (w_head == c_id_w'(m))) begin
        master_resp_o[m].rvalid = 1'b1;
        master_resp_o[m].rdata  = slave_resp_i.rdata;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      for (int e = 0; e < MAX_OUTSTANDING; e++) begin
        r_fifo[e] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
        r_rr_ptr       <= (w_sel == c_last_id) ? '0 : w_sel + 1'b1;
        r_lock         <= 1'b0;
      end else if (w_stall) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end else if (r_lock && !master_req_i[r_lock_id].req) begin
        r_lock <= 1'b0;
      end

      if (w_pop) begin
        r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
      end

      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      a_rvalid_empty : assert (!(slave_resp_i.rvalid && (r_count == '0)))
        else $warning("protocol: rvalid with no outstanding transaction, response dropped");
      a_lock_drop : assert (!(r_lock && !master_req_i[r_lock_id].req))
        else $warning("protocol: locked master withdrew its request");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitreversal_obi_arbiter.sv
// ============================================================================
// Module   : tb_bitreversal_obi_arbiter
// Brief    : Scoreboard bench for the round-robin OBI arbiter (2 and 3 masters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bitreversal_obi_arbiter;
  import bitreversal_obi_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  obi_req_t  m_req  [2];
  obi_resp_t m_resp [2];
  obi_req_t  s_req;
  obi_resp_t s_resp;

  obi_req_t  m3_req  [3];
  obi_resp_t m3_resp [3];
  obi_req_t  s3_req;
  obi_resp_t s3_resp;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];

  bitreversal_obi_arbiter #(.NUM_MASTERS(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .master_req_i(m_req), .master_resp_o(m_resp),
    .slave_req_o(s_req), .slave_resp_i(s_resp)
  );

  bitreversal_obi_arbiter #(.NUM_MASTERS(3), .MAX_OUTSTANDING(2)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .master_req_i(m3_req), .master_resp_o(m3_resp),
    .slave_req_o(s3_req), .slave_resp_i(s3_resp)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int grantee2();
    int g = -1;
    for (int m = 0; m < 2; m++) if (m_resp[m].gnt) g = (g == -1) ? m : -2;
    return g;
  endfunction

  function automatic int grantee3();
    int g = -1;
    for (int m = 0; m < 3; m++) if (m3_resp[m].gnt) g = (g == -1) ? m : -2;
    return g;
  endfunction

  // One bus cycle on the 2-master DUT: drive, settle, check grant and response routing.
  task automatic cyc(input bit r0, input bit r1, input bit gnt, input bit rv,
                     input logic [31:0] rd, input int exp_g, input string tag);
    int exp_o;
    @(posedge clk_i); #1;
    m_req[0].req  = r0;
    m_req[1].req  = r1;
    s_resp.gnt    = gnt;
    s_resp.rvalid = rv;
    s_resp.rdata  = rd;
    #2;
    check_eq({tag, ".gnt"}, grantee2(), exp_g);
    exp_o = -1;
    if (rv && sb.size() > 0) exp_o = sb.pop_front();
    if (exp_g >= 0) sb.push_back(exp_g);
    for (int m = 0; m < 2; m++) begin
      check_eq({tag, ".rvalid"}, m_resp[m].rvalid, (m == exp_o));
      check_eq({tag, ".rdata"}, m_resp[m].rdata, (m == exp_o) ? rd : 32'h0);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    for (int m = 0; m < 2; m++) m_req[m] = '0;
    for (int m = 0; m < 3; m++) m3_req[m] = '0;
    s_resp  = '0;
    s3_resp = '0;
    m_req[0].addr = 32'h100;
    m_req[1].addr = 32'h200;

    // Reset state and combinational forwarding while reset is held
    @(posedge clk_i); #1;
    #2;
    check_eq("rst.idle_req", s_req.req, 1'b0);
    check_eq("rst.idle_gnt", grantee2(), -1);
    m_req[0].req = 1'b1;
    s_resp.gnt   = 1'b1;
    #1;
    check_eq("rst.fwd_req", s_req.req, 1'b1);
    check_eq("rst.fwd_addr", s_req.addr, 32'h100);
    check_eq("rst.no_gnt", grantee2(), -1);
    check_eq("rst.no_rvalid", m_resp[0].rvalid, 1'b0);
    @(posedge clk_i); #1;
    m_req[0].req = 1'b0;
    s_resp.gnt   = 1'b0;
    rst_i        = 1'b0;

    // Test 1: alternating grants, rdata A0..A3 routed M0,M1,M0,M1
    for (int c = 0; c < 4; c++)
      cyc(1, 1, 1, c > 0, (c > 0) ? 32'(32'hA0 + c - 1) : 32'h0, c % 2, "t1");
    cyc(0, 0, 0, 1, 32'hA3, -1, "t1.tail");

    // Test 2: stalled M1 address stays locked while M0 joins
    cyc(0, 1, 0, 0, 0, -1, "t2.c0");
    check_eq("t2.c0.addr", s_req.addr, 32'h200);
    for (int c = 1; c < 3; c++) begin
      cyc(1, 1, 0, 0, 0, -1, "t2.stall");
      check_eq("t2.stall.addr", s_req.addr, 32'h200);
    end
    cyc(1, 1, 1, 0, 0, 1, "t2.c3");
    check_eq("t2.c3.addr", s_req.addr, 32'h200);
    cyc(1, 0, 1, 0, 0, 0, "t2.c4");
    cyc(0, 0, 0, 1, 32'hB0, -1, "t2.r0");
    cyc(0, 0, 0, 1, 32'hB1, -1, "t2.r1");

    // Test 3: outstanding limit, then push+pop in the same cycle while full
    cyc(1, 0, 1, 0, 0, 0, "t3.a0");
    cyc(1, 0, 1, 0, 0, 0, "t3.a1");
    cyc(1, 0, 1, 0, 0, -1, "t3.full");
    check_eq("t3.full.req", s_req.req, 1'b0);
    cyc(1, 0, 1, 1, 32'hC0, 0, "t3.pushpop");
    cyc(1, 0, 1, 0, 0, -1, "t3.still_full");
    check_eq("t3.still_full.req", s_req.req, 1'b0);
    cyc(0, 0, 0, 1, 32'hC1, -1, "t3.r1");
    cyc(0, 0, 0, 1, 32'hC2, -1, "t3.r2");

    // Test 4: write field passthrough and pointer movement
    m_req[0].we    = 1'b1;
    m_req[0].be    = 4'hF;
    m_req[0].wdata = 32'h12345678;
    m_req[0].addr  = 32'h40;
    cyc(1, 0, 1, 0, 0, 0, "t4.wr");
    check_eq("t4.we", s_req.we, 1'b1);
    check_eq("t4.be", s_req.be, 4'hF);
    check_eq("t4.wdata", s_req.wdata, 32'h12345678);
    check_eq("t4.addr", s_req.addr, 32'h40);
    cyc(1, 1, 1, 0, 0, 1, "t4.ptr1");
    cyc(1, 0, 1, 1, 32'hD0, 0, "t4.again");
    cyc(0, 0, 0, 1, 32'hD1, -1, "t4.r1");
    cyc(0, 0, 0, 1, 32'hD2, -1, "t4.r2");
    m_req[0].we    = 1'b0;
    m_req[0].be    = 4'h0;
    m_req[0].wdata = 32'h0;
    m_req[0].addr  = 32'h100;

    // Test 5: reset with two IDs outstanding discards them
    cyc(1, 1, 1, 0, 0, 1, "t5.a0");
    cyc(1, 1, 1, 0, 0, 0, "t5.a1");
    @(posedge clk_i); #1;
    m_req[0].req = 1'b0;
    m_req[1].req = 1'b0;
    s_resp.gnt   = 1'b0;
    #1 rst_i = 1'b1;
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'hEE;
    #1;
    check_eq("t5.rst.rv0", m_resp[0].rvalid, 1'b0);
    check_eq("t5.rst.rv1", m_resp[1].rvalid, 1'b0);
    @(posedge clk_i); #1;
    s_resp.rvalid = 1'b0;
    rst_i = 1'b0;
    sb.delete();
    cyc(0, 0, 0, 1, 32'hE1, -1, "t5.orphan");
    cyc(1, 1, 1, 0, 0, 0, "t5.after");
    cyc(0, 0, 0, 1, 32'hF0, -1, "t5.r0");

    // Test 6: three masters, M2 alone then pointer wrap to M0
    @(posedge clk_i); #1;
    m3_req[2].req  = 1'b1;
    m3_req[2].addr = 32'h300;
    s3_resp.gnt    = 1'b1;
    #2;
    check_eq("t6.m2_gnt", grantee3(), 2);
    check_eq("t6.m2_addr", s3_req.addr, 32'h300);
    @(posedge clk_i); #1;
    m3_req[0].req  = 1'b1;
    m3_req[0].addr = 32'h1000;
    #2;
    check_eq("t6.wrap_gnt", grantee3(), 0);
    check_eq("t6.wrap_addr", s3_req.addr, 32'h1000);
    @(posedge clk_i); #1;
    m3_req[0].req  = 1'b0;
    m3_req[2].req  = 1'b0;
    s3_resp.gnt    = 1'b0;
    s3_resp.rvalid = 1'b1;
    s3_resp.rdata  = 32'h33;
    #2;
    check_eq("t6.rv2", m3_resp[2].rvalid, 1'b1);
    check_eq("t6.rd2", m3_resp[2].rdata, 32'h33);
    check_eq("t6.rv0_idle", m3_resp[0].rvalid, 1'b0);
    @(posedge clk_i); #1;
    s3_resp.rdata = 32'h34;
    #2;
    check_eq("t6.rv0", m3_resp[0].rvalid, 1'b1);
    check_eq("t6.rd0", m3_resp[0].rdata, 32'h34);
    check_eq("t6.rv2_idle", m3_resp[2].rvalid, 1'b0);
    @(posedge clk_i); #1;
    s3_resp.rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
